skew_transpose_buffer: RTL and testbench

Multi-lane successor to the single-column transpose FIFO. It accepts a full LANES x DEPTH tile in one parallel load and drains it one column per beat, with an optional diagonal skew for systolic-array edges (lane i delayed i beats, zero-padded). It sits between the tile loader and the systolic array input edge. A one-deep pending tile register lets the next tile load while the current one drains, so consecutive tiles stream with no bubble.

---
 rtl/skew_transpose_buffer.sv | 136 +++++++++++++
 tb/tb_skew_transpose_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_transpose_buffer.sv
// Double-buffered tile transposer: loads a LANES x DEPTH tile in one beat
// and drains it one column per beat, optionally diagonally skewed.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             sync clear of active and pending tiles
//   skew_en           drain mode, captured when a tile is promoted
//   load_valid/ready  tile handshake, p_load[i][j] = lane i, entry j
//   out_valid/ready   beat handshake, q[i] = lane i entry of beat
//   out_last          final beat of the current tile
//   busy              active or pending tile present
module skew_transpose_buffer #(
    parameter int LANES = 8,
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic                                    skew_en,
    input  logic                                    load_valid,
    output logic                                    load_ready,
    input  logic [LANES-1:0][DEPTH-1:0][BITS-1:0]   p_load,
    input  logic                                    out_ready,
    output logic                                    out_valid,
    output logic                                    out_last,
    output logic [LANES-1:0][BITS-1:0]              q,
    output logic                                    busy
);

    localparam int CW = $clog2(DEPTH + LANES);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] LAST_ALIGN = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_SKEW  = CW'(DEPTH + LANES - 2);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    typedef logic [LANES-1:0][DEPTH-1:0][BITS-1:0] tile_t;

    state_t          state_q, state_d;
    tile_t           a_q, a_d;
    tile_t           p_q, p_d;
    logic            p_full_q, p_full_d;
    logic            s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            fire;
    logic            done;
    logic            promote;
    logic            load_acc;
    logic [CW-1:0]   last_cnt;

    always_comb begin
        out_valid  = (state_q == DRAIN);
        last_cnt   = s_q ? LAST_SKEW : LAST_ALIGN;
        out_last   = out_valid && (cnt_q == last_cnt);
        load_ready = !p_full_q;
        busy       = out_valid || p_full_q;
        fire       = out_valid && out_ready;
        done       = fire && out_last;
        // Promote when the active slot is empty or frees up this cycle,
        // so back-to-back tiles drain without a bubble.
        promote    = p_full_q && (!out_valid || done);
        load_acc   = load_valid && !p_full_q;
    end

    // Beat mux: in skew mode lane i lags the counter by i beats and is
    // zero outside its DEPTH-long window.
    always_comb begin
        q = '0;
        for (int i = 0; i < LANES; i++) begin
            int k;
            k = s_q ? (int'(cnt_q) - i) : int'(cnt_q);
            if (out_valid && (k >= 0) && (k < DEPTH)) begin
                q[i] = a_q[i][IW'(k)];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        p_d      = p_q;
        p_full_d = p_full_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        if (flush) begin
            state_d  = IDLE;
            p_full_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (fire) begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (promote) begin
                a_d      = p_q;
                s_d      = skew_en;
                cnt_d    = '0;
                state_d  = DRAIN;
                p_full_d = 1'b0;
            end
            if (load_acc) begin
                p_d      = p_load;
                p_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            p_q      <= '0;
            p_full_q <= 1'b0;
            s_q      <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            p_q      <= p_d;
            p_full_q <= p_full_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_skew_transpose_buffer.sv
// Scoreboard bench for skew_transpose_buffer at LANES=4, DEPTH=4, BITS=8.
// Loads push expected beats; a negedge monitor pops and compares.
module tb_skew_transpose_buffer;

    localparam int L = 4;
    localparam int D = 4;
    localparam int B = 8;

    typedef logic [L-1:0][B-1:0] row_t;
    typedef struct packed {
        row_t q;
        logic last;
    } beat_t;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic                        skew_en;
    logic                        load_valid;
    logic                        load_ready;
    logic [L-1:0][D-1:0][B-1:0]  p_load;
    logic                        out_ready;
    logic                        out_valid;
    logic                        out_last;
    row_t                        q;
    logic                        busy;

    int    errors = 0;
    int    checks = 0;
    int    beats  = 0;
    bit    gap_pending = 0;
    beat_t sb[$];

    skew_transpose_buffer #(.LANES(L), .DEPTH(D), .BITS(B)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .skew_en(skew_en),
        .load_valid(load_valid), .load_ready(load_ready),
        .p_load(p_load), .out_ready(out_ready), .out_valid(out_valid),
        .out_last(out_last), .q(q), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string nm, input row_t act, input row_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected beat c for tile p[i][j] = base + 16*i + j.
    function automatic row_t exp_row(input logic [7:0] base, input bit s,
                                     input int c);
        row_t r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            int k;
            k = s ? c - i : c;
            if (k >= 0 && k < D) r[i] = base + 8'(16 * i + k);
        end
        return r;
    endfunction

    task automatic push_tile(input logic [7:0] base, input bit s);
        int nb;
        beat_t b;
        nb = s ? D + L - 1 : D;
        for (int c = 0; c < nb; c++) begin
            b.q    = exp_row(base, s, c);
            b.last = (c == nb - 1);
            sb.push_back(b);
        end
    endtask

    task automatic load_tile(input logic [7:0] base, input bit s);
        int n;
        n = 0;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < D; j++)
                p_load[i][j] = base + 8'(16 * i + j);
        skew_en    = s;
        load_valid = 1;
        forever begin
            @(negedge clk);
            if (load_ready) break;
            n++;
            if (n > 200) break;
        end
        checks++;
        if (!load_ready) begin
            errors++;
            $display("FAIL load_accept: load_ready stuck at 0");
        end
        @(posedge clk);
        push_tile(base, s);
        #1 load_valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: drain timeout, busy=%b left=%0d", nm, busy,
                     sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string nm);
        chk1({nm, "_valid"}, out_valid, 1'b0);
        chk1({nm, "_last"}, out_last, 1'b0);
        chk1({nm, "_busy"}, busy, 1'b0);
        chk1({nm, "_ready"}, load_ready, 1'b1);
        chk_q({nm, "_q"}, q, '0);
    endtask

    task automatic aligned_with_latency(input string nm);
        load_tile(8'h00, 0);
        @(negedge clk);
        chk1({nm, "_lat_t1_valid"}, out_valid, 1'b0);
        chk1({nm, "_lat_t1_busy"}, busy, 1'b1);
        @(negedge clk);
        chk1({nm, "_lat_t2_valid"}, out_valid, 1'b1);
        wait_idle(nm);
    endtask

    // Monitor: every presented beat must match the queue head; it is
    // only consumed when out_ready is high, so stalls re-check the hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            gap_pending = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: q=%h with empty scoreboard", q);
                end else begin
                    chk_q("beat_q", q, sb[0].q);
                    chk1("beat_last", out_last, sb[0].last);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end else begin
                chk_q("idle_q_zero", q, '0);
                if (gap_pending && sb.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bubble: out_valid=0 after last beat with tile pending");
                end
            end
            gap_pending = out_valid && out_ready && out_last;
        end
    end

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int k;
        rst_n      = 0;
        flush      = 0;
        skew_en    = 0;
        load_valid = 0;
        p_load     = '0;
        out_ready  = 1;
        #1 check_idle("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;

        // Aligned drain with first-beat latency
        aligned_with_latency("aligned");

        // Skewed drain
        load_tile(8'h00, 1);
        wait_idle("skew");

        // Back-to-back tiles
        load_tile(8'h40, 0);
        load_tile(8'h80, 0);
        @(negedge clk);
        chk1("b2b_ready_low", load_ready, 1'b0);
        chk1("b2b_busy", busy, 1'b1);
        k = 0;
        while (!(out_valid && out_last) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk1("b2b_x_last_seen", out_last, 1'b1);
        @(negedge clk);
        chk1("b2b_ready_rise", load_ready, 1'b1);
        chk1("b2b_no_gap", out_valid, 1'b1);
        wait_idle("b2b");

        // Backpressure pattern 1,0,0,1
        beats = 0;
        load_tile(8'h20, 1);
        k = 0;
        while ((busy || sb.size() != 0) && k < 200) begin
            out_ready = pat[k % 4];
            @(posedge clk);
            #1;
            k++;
        end
        out_ready = 1;
        checks++;
        if (beats != D + L - 1) begin
            errors++;
            $display("FAIL bp_beat_count: got %0d expected %0d", beats, D + L - 1);
        end
        wait_idle("bp");

        // Flush at skew beat 2 with pending tile
        load_tile(8'h00, 1);
        load_tile(8'h50, 1);
        @(posedge clk);
        #1;
        flush      = 1;
        load_valid = 1;
        @(posedge clk);
        #1;
        flush      = 0;
        load_valid = 0;
        sb.delete();
        @(negedge clk);
        check_idle("flush");
        @(posedge clk);
        #1;
        load_tile(8'h10, 0);
        wait_idle("post_flush");

        // Async reset mid-drain
        load_tile(8'h55, 1);
        @(negedge clk);
        @(negedge clk);
        chk1("pre_reset_valid", out_valid, 1'b1);
        @(posedge clk);
        #3 rst_n = 0;
        #1 check_idle("async_reset");
        sb.delete();
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        aligned_with_latency("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
